// File: rtl/proc_pkg.sv
// Shared instruction-word field positions, opcode/phase constants and the opcode
// legality check used by the instruction sequencer.
package proc_pkg;

    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;
    localparam int RA_MSB  = 5;
    localparam int RA_LSB  = 3;
    localparam int RB_MSB  = 2;
    localparam int RB_LSB  = 0;

    localparam logic [2:0] OP_000 = 3'b000;
    localparam logic [2:0] OP_001 = 3'b001;
    localparam logic [2:0] OP_010 = 3'b010;
    localparam logic [2:0] OP_011 = 3'b011;
    localparam logic [2:0] OP_100 = 3'b100;
    localparam logic [2:0] OP_101 = 3'b101;
    localparam logic [2:0] OP_110 = 3'b110;
    localparam logic [2:0] OP_111 = 3'b111;

    localparam logic [1:0] PH_DECODE = 2'b00;
    localparam logic [1:0] PH_RA     = 2'b01;
    localparam logic [1:0] PH_RB     = 2'b10;
    localparam logic [1:0] PH_WB     = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } seq_state_e;

    function automatic logic opc_legal(input logic [2:0] opc);
        case (opc)
            OP_011, OP_110: return 1'b0;
            default:        return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Prefetch FIFO for instruction words: head is visible combinationally on rdata,
// synchronous flush, asynchronous reset of pointers and occupancy.
module instr_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic              do_push;
    logic              do_pop;

    assign full    = (level_reg == LVL_W'(FIFO_DEPTH));
    assign empty   = (level_reg == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem_reg[rd_ptr_reg];
    assign level   = level_reg;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push)
            mem_reg[wr_ptr_reg] <= wdata;
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction producer: buffers words in a prefetch FIFO and issues each legal one
// through four counter phases. Optional SEQ_STEP_EN adds a step input gating phase advance.
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear,
    output logic [DATA_W-1:0] inn,
    output logic [1:0]        counter,
    output logic              busy,
    output logic              instr_done,
    output logic              illegal,
`ifdef SEQ_STEP_EN
    output logic [LVL_W-1:0]  fifo_level,
    input  logic              step
`else
    output logic [LVL_W-1:0]  fifo_level
`endif
);

    seq_state_e        state_reg, state_next;
    logic [1:0]        counter_reg, counter_next;
    logic [DATA_W-1:0] inn_reg, inn_next;
    logic [DATA_W-1:0] head;
    logic              head_legal;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              advance;

`ifdef SEQ_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    assign in_ready   = ~fifo_full & ~clear;
    assign head_legal = opc_legal(head[OPC_MSB:OPC_LSB]);
    assign inn        = inn_reg;
    assign counter    = counter_reg;

    instr_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LVL_W      (LVL_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (in_valid & in_ready),
        .pop   (fifo_pop),
        .flush (clear),
        .wdata (in_data),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            counter_reg <= PH_DECODE;
            inn_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            inn_reg     <= inn_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        inn_next     = inn_reg;
        fifo_pop     = 1'b0;
        illegal      = 1'b0;
        busy         = (state_reg == ST_ISSUE);
        instr_done   = (state_reg == ST_ISSUE) && (counter_reg == PH_WB) && advance;

        // clear overrides everything; inn is deliberately held across it.
        if (clear) begin
            state_next   = ST_IDLE;
            counter_next = PH_DECODE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        if (head_legal) begin
                            inn_next     = head;
                            state_next   = ST_ISSUE;
                            counter_next = PH_DECODE;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (advance) begin
                        if (counter_reg != PH_WB) begin
                            counter_next = counter_reg + 2'd1;
                        end else begin
                            counter_next = PH_DECODE;
                            // An illegal head is left for IDLE to drop.
                            if (!fifo_empty && head_legal) begin
                                fifo_pop = 1'b1;
                                inn_next = head;
                            end else begin
                                state_next = ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_next   = ST_IDLE;
                    counter_next = PH_DECODE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations. Honours SEQ_STEP_EN.
module tb_instr_sequencer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int LVL_W  = 3;

    logic              clock    = 1'b0;
    logic              reset    = 1'b0;
    logic [DATA_W-1:0] in_data  = '0;
    logic              in_valid = 1'b0;
    logic              clear    = 1'b0;
`ifdef SEQ_STEP_EN
    logic              step     = 1'b1;
`endif
    logic              in_ready;
    logic [DATA_W-1:0] inn;
    logic [1:0]        counter;
    logic              busy;
    logic              instr_done;
    logic              illegal;
    logic [LVL_W-1:0]  fifo_level;

    int tests = 0;
    int fails = 0;

    instr_sequencer #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH),
        .LVL_W      (LVL_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .clear      (clear),
        .inn        (inn),
        .counter    (counter),
        .busy       (busy),
        .instr_done (instr_done),
        .illegal    (illegal),
`ifdef SEQ_STEP_EN
        .fifo_level (fifo_level),
        .step       (step)
`else
        .fifo_level (fifo_level)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Legal opcodes are 000,001,010,100,101,111 in bits [8:6].
    function automatic bit legal(input logic [15:0] w);
        int op;
        op = int'(w[8:6]);
        return (op == 0 || op == 1 || op == 2 || op == 4 || op == 5 || op == 7);
    endfunction

    function automatic bit adv_now();
`ifdef SEQ_STEP_EN
        return step;
`else
        return 1'b1;
`endif
    endfunction

    // Reference model: a word queue plus "instruction in flight" and its phase number.
    logic [15:0] mq[$];
    bit          m_active = 0;
    int          m_phase  = 0;
    logic [15:0] m_inn    = '0;

    initial begin
        int          pre;
        logic [15:0] h;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                mq.delete();
                m_active = 0;
                m_phase  = 0;
                m_inn    = '0;
            end else if (clear) begin
                mq.delete();
                m_active = 0;
                m_phase  = 0;
            end else begin
                pre = mq.size();
                if (!m_active) begin
                    if (pre > 0) begin
                        h = mq.pop_front();
                        if (legal(h)) begin
                            m_inn    = h;
                            m_active = 1;
                            m_phase  = 0;
                        end
                    end
                end else if (adv_now()) begin
                    if (m_phase < 3) begin
                        m_phase++;
                    end else begin
                        m_phase = 0;
                        if (mq.size() > 0 && legal(mq[0]))
                            m_inn = mq.pop_front();
                        else
                            m_active = 0;
                    end
                end
                if (in_valid && pre < DEPTH) begin
                    mq.push_back(in_data);
                    $display("[TB] push %h accepted, model level %0d", in_data, mq.size());
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    initial begin
        bit exp_ill;
        forever begin
            @(negedge clock);
            exp_ill = 0;
            if (!m_active && mq.size() > 0 && !clear)
                exp_ill = !legal(mq[0]);
            chk("m_in_ready",   in_ready,   (mq.size() < DEPTH) && !clear);
            chk("m_fifo_level", fifo_level, mq.size());
            chk("m_busy",       busy,       m_active);
            chk("m_counter",    counter,    m_active ? m_phase : 0);
            chk("m_instr_done", instr_done, m_active && m_phase == 3 && adv_now());
            chk("m_illegal",    illegal,    exp_ill);
            chk("m_inn",        inn,        m_inn);
        end
    end

    // Event monitor for directed checks.
    int          done_cnt = 0;
    int          ill_cnt  = 0;
    int          busy_cnt = 0;
    logic [15:0] issued[$];

    initial begin
        forever begin
            @(negedge clock);
            if (instr_done === 1'b1) begin
                done_cnt++;
                $display("[TB] instr_done inn=%h", inn);
            end
            if (illegal === 1'b1) begin
                ill_cnt++;
                $display("[TB] illegal word dropped");
            end
            if (busy === 1'b1) begin
                busy_cnt++;
                if (counter === 2'b00)
                    issued.push_back(inn);
            end
        end
    end

    function automatic logic [15:0] issued_at(input int i);
        if (i < issued.size())
            return issued[i];
        return 16'hxxxx;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [15:0] d, output int stalls);
        stalls   = 0;
        in_data  = d;
        in_valid = 1'b1;
        #1;
        while (in_ready !== 1'b1 && stalls < 20) begin
            tick();
            stalls++;
            #1;
        end
        if (in_ready !== 1'b1)
            chk("push_accept_timeout", in_ready, 1);
        tick();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(busy === 1'b0 && fifo_level === '0) && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_idle"}, {busy, fifo_level}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          st;
        int          d0, i0, b0, n;
        logic [15:0] w [6];

        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        tick();
        chk("rst_inn",        inn,        16'h0000);
        chk("rst_counter",    counter,    2'b00);
        chk("rst_busy",       busy,       1'b0);
        chk("rst_instr_done", instr_done, 1'b0);
        chk("rst_illegal",    illegal,    1'b0);
        chk("rst_level",      fifo_level, 0);
        chk("rst_in_ready",   in_ready,   1'b1);

        // Single legal word: inn appears two cycles after in_data.
        $display("[TB] test single word");
        push_word(16'h0053, st);
        in_valid = 1'b0;
        chk("t1_inn_early", inn, 16'h0000);
        tick();
        chk("t1_inn",  inn,     16'h0053);
        chk("t1_ph0",  counter, 2'b00);
        chk("t1_busy", busy,    1'b1);
        tick(); chk("t1_ph1", counter, 2'b01);
        tick(); chk("t1_ph2", counter, 2'b10);
        tick(); chk("t1_ph3", counter, 2'b11);
        chk("t1_done", instr_done, 1'b1);
        tick();
        chk("t1_idle_busy", busy,    1'b0);
        chk("t1_idle_cnt",  counter, 2'b00);

        // Back-to-back issue of three words.
        $display("[TB] test back-to-back");
        issued.delete(); d0 = done_cnt; b0 = busy_cnt;
        push_word(16'h0011, st);
        push_word(16'h0100, st);
        push_word(16'h01C7, st);
        in_valid = 1'b0;
        wait_idle("t2");
        chk("t2_done_pulses", done_cnt - d0, 3);
        chk("t2_busy_cycles", busy_cnt - b0, 12);
        chk("t2_issue0", issued_at(0), 16'h0011);
        chk("t2_issue1", issued_at(1), 16'h0100);
        chk("t2_issue2", issued_at(2), 16'h01C7);
        chk("t2_issue_n", issued.size(), 3);

        // Illegal opcode 011 is dropped, following legal word issues.
        $display("[TB] test illegal drop");
        issued.delete(); i0 = ill_cnt;
        push_word(16'h00C9, st);
        push_word(16'h0009, st);
        in_valid = 1'b0;
        wait_idle("t3");
        chk("t3_illegal_pulses", ill_cnt - i0, 1);
        chk("t3_issue_n", issued.size(), 1);
        chk("t3_issue0", issued_at(0), 16'h0009);

        // Backpressure: six words while one instruction is in flight.
        $display("[TB] test full fifo");
        issued.delete(); d0 = done_cnt;
        w[0] = 16'h0041; w[1] = 16'h0102; w[2] = 16'h0143;
        w[3] = 16'h0004; w[4] = 16'h0085; w[5] = 16'h01C6;
        for (int i = 0; i < 5; i++) begin
            push_word(w[i], st);
            chk("t4_no_stall", st, 0);
        end
        in_data = w[5];
        #1;
        chk("t4_full_level", fifo_level, 4);
        chk("t4_full_ready", in_ready,   1'b0);
        push_word(w[5], st);
        chk("t4_stall_w5", st, 1);
        in_valid = 1'b0;
        wait_idle("t4");
        chk("t4_done_pulses", done_cnt - d0, 6);
        chk("t4_issue_n", issued.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("t4_issue_order", issued_at(i), w[i]);

        // Clear at counter=01 with level=3 and a pending push.
        $display("[TB] test clear");
        issued.delete();
        push_word(16'h0048, st);
        push_word(16'h0090, st);
        push_word(16'h0118, st);
        push_word(16'h0160, st);
        push_word(16'h01E1, st);
        in_valid = 1'b0;
        n = 0;
        while (!(busy === 1'b1 && counter === 2'b01 && inn === 16'h0090) && n < 20) begin
            tick();
            n++;
        end
        chk("t5_pre_counter", counter,    2'b01);
        chk("t5_pre_level",   fifo_level, 3);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h0022;
        #1;
        chk("t5_ready_in_clear", in_ready, 1'b0);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t5_counter", counter,    2'b00);
        chk("t5_busy",    busy,       1'b0);
        chk("t5_level",   fifo_level, 0);
        chk("t5_inn_held", inn,       16'h0090);
        chk("t5_done",    instr_done, 1'b0);
        repeat (6) tick();
        chk("t5_issue_n", issued.size(), 2);
        chk("t5_issue0", issued_at(0), 16'h0048);
        chk("t5_issue1", issued_at(1), 16'h0090);
        chk("t5_still_idle", busy, 1'b0);

`ifdef SEQ_STEP_EN
        // Step gating: counter holds with step low.
        $display("[TB] test step");
        push_word(16'h0053, st);
        in_valid = 1'b0;
        tick();
        chk("ts_ph0", counter, 2'b00);
        tick();
        chk("ts_ph1", counter, 2'b01);
        step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ts_hold", counter, 2'b01);
        end
        step = 1'b1;
        tick();
        chk("ts_step", counter, 2'b10);
        step = 1'b0;
        tick();
        chk("ts_hold2", counter, 2'b10);
        step = 1'b1;
        wait_idle("ts");
`endif

        // Asynchronous reset in the middle of an instruction.
        $display("[TB] test async reset");
        push_word(16'h0053, st);
        in_valid = 1'b0;
        n = 0;
        while (counter !== 2'b10 && n < 10) begin
            tick();
            n++;
        end
        chk("t6_pre_counter", counter, 2'b10);
        #2 reset = 1'b1;
        #1;
        chk("t6_counter", counter,    2'b00);
        chk("t6_busy",    busy,       1'b0);
        chk("t6_inn",     inn,        16'h0000);
        chk("t6_level",   fifo_level, 0);
        chk("t6_done",    instr_done, 1'b0);
        chk("t6_illegal", illegal,    1'b0);
        #2 reset = 1'b0;
        tick();
        tick();
        chk("t6_after_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Producer side of the control unit's instruction interface.
- Accepts 16-bit instruction words over a valid/ready stream and buffers them in a small prefetch FIFO.
- Holds the current word on inn and drives the 2-bit phase counter through 00→01→10→11 for each legal instruction.
- Honours the control unit's clear (abort + flush) and drops illegal opcodes.

Parameters:
- DATA_W, 16, instruction word width.
- FIFO_DEPTH, 4, prefetch entries; power of 2, ≥2.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of fifo_level.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_data  in  DATA_W  instruction word; fields are [8:6] opcode, [5:3] first reg, [2:0] second reg.
- in_valid  in  1  in_data valid.
- in_ready  out  1  = !full & !clear (combinational).
- clear  in  1  synchronous abort/flush from the control unit.
- inn  out  DATA_W  current instruction register.
- counter  out  2  phase of the current instruction.
- busy  out  1  high while in ISSUE.
- instr_done  out  1  high in the counter==11 cycle.
- illegal  out  1  one-cycle pulse when an illegal word is dropped.
- fifo_level  out  LVL_W  occupancy, 0..FIFO_DEPTH.
- step  in  1  present only with SEQ_STEP_EN.

Behaviour:
- Reset (async, active-high) forces:
  - inn=0, counter=00, busy=0, instr_done=0, illegal=0, fifo_level=0.
  - FIFO emptied, state IDLE.
- Legal opcodes: 000, 001, 010, 100, 101, 111. Illegal: 011, 110.
- FIFO:
  - Push on in_valid & in_ready.
  - Pop only when the FSM requests it and FIFO is non-empty.
  - Push and pop in the same cycle: level unchanged.
  - Full: in_ready=0. There is no full pass-through.
  - Pointers wrap modulo FIFO_DEPTH.
  - A push into an empty FIFO is visible to the FSM the next cycle; minimum in_data→inn latency is 2 cycles.
- FSM, state IDLE:
  - counter=00, busy=0.
  - If FIFO non-empty and head is legal: pop, inn←head, go ISSUE with counter=00.
  - If head is illegal: pop, illegal=1 for one cycle, inn unchanged, stay IDLE.
  - At most one pop per cycle.
- FSM, state ISSUE:
  - busy=1; counter increments by 1 each cycle.
  - In the counter==11 cycle, instr_done=1.
  - Leaving 11: if FIFO non-empty and head is legal, pop and load inn; counter wraps to 00 and state stays ISSUE (back-to-back, no bubble).
  - Otherwise go to IDLE with counter=00.
- inn is stable for all four phases of an instruction.
- clear=1 (any state):
  - Next edge: state IDLE, counter=00, FIFO flushed (level 0), instr_done=0, illegal=0, inn held.
  - A push in the same cycle is refused (in_ready=0).
  - clear has priority over every other event.
- Reset mid-instruction: immediate async return to reset values; the partial instruction is lost.

Optional Feature:
- Macro: SEQ_STEP_EN.
- Defined:
  - step port exists.
  - In ISSUE, counter advances (and the 11→next transition occurs) only on cycles with step=1.
  - instr_done is asserted only in a counter==11 cycle with step=1.
  - IDLE→ISSUE load does not require step.
  - clear and reset are unaffected.
- Undefined: no step port; free-running behaviour as above.

Decomposition:
- Package proc_pkg:
  - Field positions: OPC_MSB=8, OPC_LSB=6, RA_MSB=5, RA_LSB=3, RB_MSB=2, RB_LSB=0.
  - Opcode constants OP_000..OP_111.
  - Phase constants PH_DECODE=00, PH_RA=01, PH_RB=10, PH_WB=11.
  - Function opc_legal(opcode).
- One sub-module, instr_fifo:
  - Parameterised DATA_W/FIFO_DEPTH.
  - Ports: push, pop, wdata, rdata, full, empty, level, flush.
  - Synchronous flush, async reset.
- FSM and counter stay in instr_sequencer.

Test Plan:
- Single legal word: push 16'h0053 (opc 001, ra 2, rb 3) into an idle block.
  - Two cycles later inn=0053, counter 00,01,10,11 on consecutive cycles.
  - instr_done in the 11 cycle; then IDLE, busy=0.
- Back-to-back: push 0x0011, 0x0100, 0x01C7 in consecutive cycles.
  - counter sequence 00..11 three times with no gap; three instr_done pulses; inn changes exactly at each wrap.
- Illegal drop: push 0x00C9 (opc 011) then 0x0009.
  - illegal pulses once; 0x00C9 never appears on inn; 0x0009 then issues normally.
- Full/backpressure: hold issue busy and push 5 words with FIFO_DEPTH=4.
  - in_ready drops when level=4; the 5th word is accepted only after the first pop.
  - No word is lost or duplicated.
- Clear mid-instruction: assert clear at counter=01 with level=3 and in_valid=1.
  - Next cycle: counter=00, busy=0, level=0, in_ready=0 during clear; the pending push is discarded.
- Async reset at counter=10: outputs go to reset values without waiting for a clock edge.
  - With SEQ_STEP_EN, additionally check counter holds at 01 for 3 cycles with step=0 and advances on a single step pulse.
